// File: rtl/uart_rx_fifo.sv
// UART receiver (majority-voted samples, parity/stop checks) feeding a first-word-fall-through word FIFO.
// Word visible one cycle after the final stop decision; a full FIFO with no same-cycle pop drops it and sets overrun.

module uart_rx_fifo_buf #(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_vld,
  input  logic [W-1:0]           wr_dat,
  output logic                   wr_rdy,
  output logic                   rd_vld,
  output logic [W-1:0]           rd_dat,
  input  logic                   rd_rdy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_fire;
  logic          rd_fire;

  assign rd_vld  = (count != '0);
  assign rd_fire = rd_rdy && rd_vld;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside a pop.
  assign wr_rdy  = (count != FULL) || rd_fire;
  assign wr_fire = wr_vld && wr_rdy;
  assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      if (wr_fire && !rd_fire)      count <= count + 1'b1;
      else if (rd_fire && !wr_fire) count <= count - 1'b1;
    end
  end
endmodule

module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 25_500_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rxd,
  input  logic                        rd_en,
  output logic                        rd_valid,
  output logic [DATA_BITS-1:0]        rd_data,
  output logic                        rd_frame_err,
  output logic                        rd_parity_err,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overrun,
  input  logic                        clr_overrun
);
  localparam int BIT_PERIOD = CLOCK_FREQ / BAUD;
  localparam int CW         = $clog2(BIT_PERIOD);
  localparam int WW         = DATA_BITS + 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] SMP_A    = CW'(BIT_PERIOD / 2 - 1);
  localparam logic [CW-1:0] SMP_B    = CW'(BIT_PERIOD / 2);
  localparam logic [CW-1:0] SMP_C    = CW'(BIT_PERIOD / 2 + 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rxs;
  logic                 rxs_d;
  logic [CW-1:0]        bit_cnt;
  logic [3:0]           bit_idx;
  logic [1:0]           smp;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 frm_err;
  logic                 decide;
  logic                 vote;
  logic                 push_vld;
  logic                 push_rdy;
  logic [WW-1:0]        push_dat;
  logic [WW-1:0]        head;

  assign decide   = (bit_cnt == SMP_C);
  assign vote     = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
  // Push straight from the final stop decision so the word lands in the FIFO on that edge.
  assign push_vld = (state == STOP) && decide && (bit_idx == LAST_STOP);
  assign push_dat = {frm_err | ~vote, par_err, shreg};

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      smp     <= '0;
      shreg   <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
      bit_cnt <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
      if (bit_cnt == SMP_A) smp[0] <= rxs;
      if (bit_cnt == SMP_B) smp[1] <= rxs;
      case (state)
        // Needs a genuine 1->0 edge, so a held-low line yields only one word.
        IDLE: if (rxs_d && !rxs) begin
          state   <= START;
          bit_cnt <= '0;
          bit_idx <= '0;
          par_err <= 1'b0;
          frm_err <= 1'b0;
        end
        START: if (decide) state <= vote ? IDLE : DATA;
        DATA: if (decide) begin
          shreg   <= {vote, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == LAST_DATA) begin
            bit_idx <= '0;
            state   <= (PARITY != 0) ? PAR : STOP;
          end
        end
        PAR: if (decide) begin
          par_err <= (PARITY == 1) ? ~(^shreg ^ vote) : (^shreg ^ vote);
          state   <= STOP;
        end
        STOP: if (decide) begin
          frm_err <= frm_err | ~vote;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == LAST_STOP) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                        overrun <= 1'b0;
    else if (push_vld && !push_rdy) overrun <= 1'b1;
    else if (clr_overrun)           overrun <= 1'b0;
  end

  uart_rx_fifo_buf #(.W(WW), .DEPTH(FIFO_DEPTH)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push_vld),
    .wr_dat (push_dat),
    .wr_rdy (push_rdy),
    .rd_vld (rd_valid),
    .rd_dat (head),
    .rd_rdy (rd_en),
    .count  (count)
  );

  assign rd_data       = head[DATA_BITS-1:0];
  assign rd_parity_err = head[WW-2];
  assign rd_frame_err  = head[WW-1];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1/16-deep instance and a fast 7E2/4-deep instance against a word-queue model.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd_a = 1'b1, rd_en_a = 1'b0, clr_a = 1'b0;
  logic       rxd_b = 1'b1, rd_en_b = 1'b0, clr_b = 1'b0;
  logic       rd_valid_a, rd_frame_err_a, rd_parity_err_a, overrun_a;
  logic       rd_valid_b, rd_frame_err_b, rd_parity_err_b, overrun_b;
  logic [7:0] rd_data_a;
  logic [6:0] rd_data_b;
  logic [4:0] count_a;
  logic [2:0] count_b;

  int vectors = 0;
  int miscompares = 0;
  int read_pct_a = 0;
  int read_pct_b = 0;
  bit exp_ovr_a = 1'b0;
  bit exp_ovr_b = 1'b0;
  // Expected words, oldest first: {frame_err, parity_err, data[8:0]}
  logic [10:0] qa[$];
  logic [10:0] qb[$];

  uart_rx_fifo dut_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .rd_en(rd_en_a), .rd_valid(rd_valid_a),
    .rd_data(rd_data_a), .rd_frame_err(rd_frame_err_a), .rd_parity_err(rd_parity_err_a),
    .count(count_a), .overrun(overrun_a), .clr_overrun(clr_a));

  uart_rx_fifo #(.CLOCK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .rd_en(rd_en_b), .rd_valid(rd_valid_b),
    .rd_data(rd_data_b), .rd_frame_err(rd_frame_err_b), .rd_parity_err(rd_parity_err_b),
    .count(count_b), .overrun(overrun_b), .clr_overrun(clr_b));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded 100000 cycles");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_push(input bit sel, input logic [10:0] w);
    if (sel) begin
      if (qb.size() == 4) exp_ovr_b = 1'b1; else qb.push_back(w);
    end else begin
      if (qa.size() == 16) exp_ovr_a = 1'b1; else qa.push_back(w);
    end
  endfunction

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rxd_b = v; else rxd_a = v;
  endtask

  task automatic idle(input bit sel, input int n);
    set_rx(sel, 1'b1);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input bit sel, input logic v, input int period, input bit glitch);
    for (int i = 0; i < period; i++) begin
      @(negedge clk);
      set_rx(sel, (glitch && i == period / 2) ? ~v : v);
    end
  endtask

  // sel=0: 8 data bits, no parity, 1 stop; sel=1: 7 data bits, even parity, 2 stops
  task automatic send(input bit sel, input logic [8:0] data, input logic pbit,
                      input logic [1:0] stops, input int period, input int glitch_bit);
    int nb;
    logic [10:0] w;
    nb = sel ? 7 : 8;
    drive_bit(sel, 1'b0, period, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(sel, data[i], period, i == glitch_bit);
    if (sel) drive_bit(sel, pbit, period, 1'b0);
    w = {~(stops[0] & (sel ? stops[1] : 1'b1)), sel ? (^data[6:0] ^ pbit) : 1'b0,
         data & (sel ? 9'h07F : 9'h0FF)};
    model_push(sel, w);
    drive_bit(sel, stops[0], period, 1'b0);
    if (sel) drive_bit(sel, stops[1], period, 1'b0);
    if (!(sel ? stops[1] : stops[0])) drive_bit(sel, 1'b1, period, 1'b0);
  endtask

  task automatic send_ok(input bit sel, input logic [8:0] data);
    send(sel, data, ^data[6:0], 2'b11, sel ? 16 : 221, -1);
  endtask

  task automatic drain(input bit sel, input string name);
    int n = 0;
    if (sel) read_pct_b = 100; else read_pct_a = 100;
    while ((sel ? rd_valid_b : rd_valid_a) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sel) read_pct_b = 0; else read_pct_a = 0;
    @(negedge clk);
    check(name, sel ? 32'(count_b) : 32'(count_a), 0);
    check({name, "_undelivered"}, sel ? qb.size() : qa.size(), 0);
  endtask

  // Head of each FIFO must equal the oldest model word whenever valid; pops are random.
  always @(negedge clk) begin
    logic [10:0] got;
    logic [10:0] exp;
    if (rst) begin
      rd_en_a = 1'b0;
      rd_en_b = 1'b0;
    end else begin
      rd_en_a = ($urandom_range(99) < read_pct_a);
      rd_en_b = ($urandom_range(99) < read_pct_b);
      if (rd_valid_a) begin
        got = {rd_frame_err_a, rd_parity_err_a, 1'b0, rd_data_a};
        if (qa.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL a_head: got 0x%0h, expected no word", got);
        end else begin
          check("a_head", got, qa[0]);
          if (rd_en_a) exp = qa.pop_front();
        end
      end
      if (rd_valid_b) begin
        got = {rd_frame_err_b, rd_parity_err_b, 2'b00, rd_data_b};
        if (qb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL b_head: got 0x%0h, expected no word", got);
        end else begin
          check("b_head", got, qb[0]);
          if (rd_en_b) exp = qb.pop_front();
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid_a", rd_valid_a, 0);
    check("rst_data_a", rd_data_a, 0);
    check("rst_count_a", count_a, 0);
    check("rst_ovr_a", overrun_a, 0);
    check("rst_valid_b", rd_valid_b, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 7E2: parity and second-stop errors
    send(1, 9'h01, 1'b0, 2'b11, 16, -1);
    check("b_perr_bad", rd_parity_err_b, 1);
    check("b_perr_bad_data", rd_data_b, 7'h01);
    check("b_perr_bad_ferr", rd_frame_err_b, 0);
    drain(1, "b_drain1");
    send(1, 9'h01, 1'b1, 2'b11, 16, -1);
    check("b_perr_ok", rd_parity_err_b, 0);
    drain(1, "b_drain2");
    send(1, 9'h01, 1'b1, 2'b01, 16, -1);
    check("b_stop2_ferr", rd_frame_err_b, 1);
    check("b_stop2_perr", rd_parity_err_b, 0);
    drain(1, "b_drain3");

    // Break: one all-zero word with frame error, nothing more while the line stays low
    model_push(1, {1'b1, 1'b0, 9'h000});
    set_rx(1, 1'b0);
    repeat (400) @(negedge clk);
    idle(1, 48);
    check("b_break_count", count_b, 1);
    check("b_break_ferr", rd_frame_err_b, 1);
    check("b_break_data", rd_data_b, 0);
    drain(1, "b_drain4");

    for (int i = 0; i < 5; i++) send_ok(1, 9'(i + 3));
    check("b_full_count", count_b, 4);
    check("b_ovr_set", overrun_b, 1);
    check("b_ovr_model", overrun_b, exp_ovr_b);
    drain(1, "b_drain5");
    check("b_ovr_sticky", overrun_b, 1);

    read_pct_b = 30;
    for (int i = 0; i < 10; i++) begin
      send(1, 9'($urandom_range(127)), 1'($urandom_range(1)), 2'($urandom_range(3)), 16, -1);
      idle(1, $urandom_range(40));
    end
    drain(1, "b_drain_rand");

    // 8N1 single word, then pop
    send_ok(0, 9'h0A5);
    check("t1_valid", rd_valid_a, 1);
    check("t1_data", rd_data_a, 8'hA5);
    check("t1_ferr", rd_frame_err_a, 0);
    check("t1_perr", rd_parity_err_a, 0);
    check("t1_count", count_a, 1);
    read_pct_a = 100;
    @(negedge clk);
    @(negedge clk);
    check("t1_pop_valid", rd_valid_a, 0);
    read_pct_a = 0;
    check("t1_model_empty", qa.size(), 0);

    // False start
    set_rx(0, 1'b0);
    repeat (50) @(negedge clk);
    idle(0, 442);
    check("t2_no_push", count_a, 0);
    check("t2_valid", rd_valid_a, 0);
    send_ok(0, 9'h03C);
    check("t2_data", rd_data_a, 8'h3C);
    drain(0, "t2_drain");

    send(0, 9'h05A, 1'b0, 2'b10, 221, -1);
    check("t3_data", rd_data_a, 8'h5A);
    check("t3_ferr", rd_frame_err_a, 1);
    drain(0, "t3_drain");

    // Overflow: 17 frames into 16 entries
    for (int i = 0; i < 17; i++) send_ok(0, 9'(i));
    check("t5_count", count_a, 16);
    check("t5_ovr", overrun_a, 1);
    check("t5_ovr_model", overrun_a, exp_ovr_a);
    check("t5_head", rd_data_a, 0);
    drain(0, "t5_drain");
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    @(negedge clk);
    check("t5_clr", overrun_a, 0);

    read_pct_a = 20;
    for (int i = 0; i < 3; i++) begin
      send_ok(0, 9'($urandom_range(255)));
      idle(0, $urandom_range(300));
    end
    drain(0, "a_drain_rand");

    // Glitch on a zero data bit, then -3% and +3% baud skew
    read_pct_a = 100;
    send(0, 9'h0F0, 1'b0, 2'b11, 221, 0);
    send(0, 9'($urandom_range(255)), 1'b0, 2'b11, 214, -1);
    send(0, 9'($urandom_range(255)), 1'b0, 2'b11, 228, -1);
    idle(0, 4);
    check("t6_model_empty", qa.size(), 0);
    read_pct_a = 0;

    // Reset with a word held and a frame in flight
    send_ok(0, 9'h077);
    check("t6_held", rd_data_a, 8'h77);
    drive_bit(0, 1'b0, 221, 1'b0);
    drive_bit(0, 1'b1, 221, 1'b0);
    drive_bit(0, 1'b0, 110, 1'b0);
    set_rx(0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    qa.delete();
    qb.delete();
    exp_ovr_a = 1'b0;
    exp_ovr_b = 1'b0;
    check("t6_rst_valid", rd_valid_a, 0);
    check("t6_rst_data", rd_data_a, 0);
    check("t6_rst_ferr", rd_frame_err_a, 0);
    check("t6_rst_count", count_a, 0);
    check("t6_rst_ovr_b", overrun_b, 0);
    idle(0, 442);
    check("t6_no_spurious", count_a, 0);
    send_ok(0, 9'h0C3);
    check("t6_c3_data", rd_data_a, 8'hC3);
    check("t6_c3_errs", {rd_frame_err_a, rd_parity_err_a}, 0);
    check("t6_c3_count", count_a, 1);
    drain(0, "t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
